serial_cmd_engine: RTL and testbench
====================================

// Module: serial_cmd_engine
// PURPOSE
//  Parametrised successor to the byte-serial command processor between the UART rx/tx pair and the trigger core.
//  Decodes 1-byte opcodes and their argument bytes, and drives the configuration registers
//  (line drivers, PLL phases, passthrough, PMT veto, test pulses).
//  Streams a snapshot of NUM_HIST histogram bins plus two aux counters with a trailing XOR checksum.
//  New over the previous generation:
//  - width/count parametrisation;
//  - argument timeout;
//  - NAK byte on bad or timed-out commands;
//  - no 136-byte output buffer: bytes are muxed from a snapshot.
// PARAMETERS
//  NUM_HIST    32         histogram bins streamed by SEND_HISTOGRAM
//  HIST_W      32         bits per bin/aux counter; multiple of 8
//  NUM_PLL     6          PLL phase-shift bytes taken by SET_PLL
//  VERSION     8'd24      firmware version byte returned by opcode 0
//  ARG_TIMEOUT 1_000_000  clk cycles allowed between argument bytes
//  NAK_BYTE    8'hEE      byte sent on bad opcode or timeout
// PORTS
//  clk                   in   1               system clock; all logic on posedge
//  reset                 in   1               synchronous, active-high
//  rx_ready              in   1               one-cycle strobe: rx_data valid
//  rx_data               in   8               received byte
//  tx_busy               in   1               UART transmitter busy
//  tx_start              out  1               one-cycle pulse: send tx_data
//  tx_data               out  8               byte to transmit
//  hist                  in   NUM_HIST*HIST_W bin i at [i*HIST_W +: HIST_W]
//  hist_aux              in   2*HIST_W        aux counters 0,1
//  resethist             out  1               one-cycle pulse clearing histograms
//  updatepll             out  1               one-cycle pulse: apply pll_shifts
//  pll_shifts            out  NUM_PLL*8       byte k at [k*8 +: 8]
//  disable_line_drivers  out  1               reset 1 (drivers off)
//  enable_debug_outputs  out  1               reset 0
//  passthrough           out  1               reset 0
//  vetopmtlast           out  3               reset 3'b001
//  useInternalTestPulse  out  1               reset 0
//  useExternalTestPulse  out  1               reset 0
//  cmd_error             out  1               sticky: bad opcode/timeout seen; cleared by opcode 0
//  ledIndicators         out  8               last opcode; bit7 = sending, bit6 = awaiting args
// BEHAVIOUR
//  Reset: all outputs take the values listed above; every other output is 0.
//   Reset aborts any transfer immediately, with no partial-byte completion.
//  Opcodes and argument counts:
//   0 VERSION  0   1 SET_OUTPUTS  1   2 SET_PLL  NUM_PLL   3 SET_PASSTHROUGH  1
//   4 SEND_HIST  0   5 SET_PMT_VETO  1   6 RESET_PLL  0   7 SET_TEST_INPUTS  1
//   Any other opcode: send NAK_BYTE, set cmd_error, return to IDLE.
//  States: IDLE -> ARGS -> EXEC -> (TX_LOAD -> TX_PULSE -> TX_WAIT)* | UPD_PLL -> IDLE.
//  IDLE:
//   - rx_ready latches the opcode.
//   - Goes to ARGS if the argument count > 0, else EXEC.
//  ARGS:
//   - Each rx_ready stores the byte at index argcnt and increments argcnt.
//   - The idle counter resets on each byte.
//   - If the idle counter reaches ARG_TIMEOUT: NAK, cmd_error=1, no register change.
//  EXEC: applies the decoded update one cycle after the final argument.
//   SET_OUTPUTS      disable_line_drivers = !a0[0]; enable_debug_outputs = a0[1]
//   SET_PLL          pll_shifts = args; then UPD_PLL
//   SET_PASSTHROUGH  passthrough = (a0 != 0)
//   SET_PMT_VETO     vetopmtlast = a0[2:0]
//   RESET_PLL        pll_shifts = 0; then UPD_PLL
//   SET_TEST_INPUTS  int = a0[0]; ext = a0[1]
//  UPD_PLL: updatepll = 1 for exactly one cycle.
//  SEND_HIST (in EXEC):
//   - Snapshots hist and hist_aux into internal registers.
//   - Pulses resethist in the same cycle.
//   - Stream length N = (NUM_HIST+2)*HIST_W/8 + 1 bytes.
//   - Order: bins 0..NUM_HIST-1, then aux0, aux1; each little-endian.
//   - Last byte: XOR of all preceding N-1 bytes.
//   - Counts arriving after the snapshot are not lost by the core; they count into the cleared bins.
//  TX handshake, per byte:
//   - TX_LOAD waits for !tx_busy, then sets tx_data.
//   - TX_PULSE: tx_start = 1 for one cycle.
//   - TX_WAIT: one guard cycle, then loop back to TX_LOAD or exit.
//   - tx_data stays stable from TX_LOAD until the next TX_LOAD.
//  rx_ready while transmitting or in EXEC/UPD_PLL is ignored (dropped).
//   Host must wait for the reply.
//  Single-byte replies (VERSION, NAK) use the same TX path.
// STRUCTURE
//  Package serial_cmd_pkg holds:
//   - the opcode enum;
//   - the state enum;
//   - the function nargs(opcode) returning the argument count;
//   - led bit masks and NAK_BYTE.
//  Sub-module serial_tx_seq:
//   - inputs: byte-index request, byte_valid;
//   - drives the TX handshake;
//   - owns the byte counter and XOR accumulator.
// TESTING
//  1. rx 0x00 -> exactly one tx_start with tx_data = VERSION; cmd_error cleared.
//  2. rx 0x02, 01,02,03,04,05,06 -> pll_shifts = 0x060504030201; one updatepll pulse.
//  3. hist[i] = 32'h0100_0000*i + i, aux = {32'hDEADBEEF, 32'h12345678}; rx 0x04 ->
//     137 bytes; bytes 128..131 = 78 56 34 12; checksum correct; one resethist pulse.
//  4. rx 0x05 then silence for ARG_TIMEOUT cycles -> tx NAK_BYTE 0xEE;
//     cmd_error = 1; vetopmtlast unchanged at 3'b001.
//  5. rx 0x1F -> NAK; rx 0x01, 0x03 -> disable_line_drivers = 0 and enable_debug_outputs = 1.
//  6. Hold tx_busy high for 50 cycles mid-histogram, then assert reset mid-stream ->
//     no tx_start while busy; all outputs at reset values the next cycle.

Source files
------------

// File: rtl/serial_cmd_engine_pkg.sv
// Shared opcode/state types and decode helpers for the serial command engine
// and its byte-serial TX sequencer.
package serial_cmd_pkg;

  typedef enum logic [7:0] {
    OP_VERSION         = 8'd0,
    OP_SET_OUTPUTS     = 8'd1,
    OP_SET_PLL         = 8'd2,
    OP_SET_PASSTHROUGH = 8'd3,
    OP_SEND_HIST       = 8'd4,
    OP_SET_PMT_VETO    = 8'd5,
    OP_RESET_PLL       = 8'd6,
    OP_SET_TEST_INPUTS = 8'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_EXEC,
    ST_SEND,
    ST_UPD_PLL
  } state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_PULSE,
    TX_WAIT
  } tx_state_e;

  localparam logic [7:0] LED_SENDING      = 8'h80;
  localparam logic [7:0] LED_ARGS         = 8'h40;
  localparam logic [7:0] DEFAULT_NAK_BYTE = 8'hEE;

  function automatic logic op_valid(input logic [7:0] op);
    return op < 8'd8;
  endfunction

  // Unknown opcodes take no arguments so they fall straight through to the NAK.
  function automatic int unsigned nargs(input logic [7:0] op, input int unsigned num_pll);
    case (op)
      OP_SET_OUTPUTS, OP_SET_PASSTHROUGH,
      OP_SET_PMT_VETO, OP_SET_TEST_INPUTS: return 1;
      OP_SET_PLL:                          return num_pll;
      default:                             return 0;
    endcase
  endfunction

endpackage

// File: rtl/serial_cmd_engine_if.sv
// Byte-level UART handshake between the command engine and the rx/tx pair.
interface serial_cmd_engine_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (output rx_ready, rx_data, tx_busy, input tx_start, tx_data);
  modport slave  (input rx_ready, rx_data, tx_busy, output tx_start, tx_data);
endinterface

// File: rtl/serial_cmd_engine_tx_seq.sv
// Streams nbytes requested bytes (plus an optional trailing XOR checksum)
// through the UART start/busy handshake.
module serial_tx_seq
  import serial_cmd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] nbytes,
  input  logic             with_csum,
  output logic [CNT_W-1:0] byte_idx,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             active
);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, total_q;
  logic             csum_q;
  logic [7:0]       acc_q;
  logic             last_byte, is_csum;

  assign last_byte = (cnt_q == total_q - CNT_W'(1));
  assign is_csum   = csum_q && last_byte;
  assign tx_start  = (state_q == TX_PULSE);
  assign active    = (state_q != TX_IDLE);
  assign byte_idx  = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= TX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (start) state_d = TX_LOAD;
      TX_LOAD:  if (!tx_busy && (byte_valid || is_csum)) state_d = TX_PULSE;
      TX_PULSE: state_d = TX_WAIT;
      TX_WAIT:  state_d = last_byte ? TX_IDLE : TX_LOAD;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      total_q <= '0;
      csum_q  <= 1'b0;
      tx_data <= '0;
    end else begin
      if (state_q == TX_IDLE && start) begin
        cnt_q   <= '0;
        total_q <= nbytes + CNT_W'(with_csum);
        csum_q  <= with_csum;
      end
      // tx_data only moves on the LOAD->PULSE edge so it is stable across the whole byte
      if (state_q == TX_LOAD && state_d == TX_PULSE && !is_csum) tx_data <= byte_data;
      if (state_q == TX_LOAD && state_d == TX_PULSE && is_csum)  tx_data <= acc_q;
      if (state_q == TX_WAIT) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == TX_IDLE && start) acc_q <= '0;
    else if (state_q == TX_LOAD && state_d == TX_PULSE && !is_csum) acc_q <= acc_q ^ byte_data;
  end

endmodule

// File: rtl/serial_cmd_engine.sv
// Byte-serial command decoder: configuration registers, PLL phase updates and
// histogram snapshot streaming back over the UART.
module serial_cmd_engine
  import serial_cmd_pkg::*;
#(
  parameter int         NUM_HIST    = 32,
  parameter int         HIST_W      = 32,
  parameter int         NUM_PLL     = 6,
  parameter logic [7:0] VERSION     = 8'd24,
  parameter int         ARG_TIMEOUT = 1_000_000,
  parameter logic [7:0] NAK_BYTE    = DEFAULT_NAK_BYTE
) (
  input  logic                       clk,
  input  logic                       reset,
  serial_cmd_engine_if.slave         sif,
  input  logic [NUM_HIST*HIST_W-1:0] hist,
  input  logic [2*HIST_W-1:0]        hist_aux,
  output logic                       resethist,
  output logic                       updatepll,
  output logic [NUM_PLL*8-1:0]       pll_shifts,
  output logic                       disable_line_drivers,
  output logic                       enable_debug_outputs,
  output logic                       passthrough,
  output logic [2:0]                 vetopmtlast,
  output logic                       useInternalTestPulse,
  output logic                       useExternalTestPulse,
  output logic                       cmd_error,
  output logic [7:0]                 ledIndicators
);

  localparam int SNAP_BYTES = (NUM_HIST + 2) * HIST_W / 8;
  localparam int CNT_W      = $clog2(SNAP_BYTES + 2);
  localparam int SIDX_W     = $clog2(SNAP_BYTES);
  localparam int ARG_W      = $clog2(NUM_PLL + 1);
  localparam int TO_W       = $clog2(ARG_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [7:0]       opcode_q;
  logic [7:0]       args_q [NUM_PLL];
  logic [ARG_W-1:0] argcnt_q;
  logic [TO_W-1:0]  idle_q;
  logic             nak_q, hist_mode_q;
  logic [7:0]       reply_q;
  logic [7:0]       snap_q [SNAP_BYTES];
  logic [SNAP_BYTES*8-1:0] snap_flat;
  logic             arg_last, arg_timeout, bad_cmd;
  logic             tx_go, tx_csum, seq_active, byte_valid;
  logic [CNT_W-1:0] tx_len, byte_idx;
  logic [7:0]       byte_data;

  assign snap_flat   = {hist_aux, hist};
  assign arg_last    = (32'(argcnt_q) + 32'd1 == nargs(opcode_q, NUM_PLL));
  assign arg_timeout = (idle_q == TO_W'(ARG_TIMEOUT - 1));
  assign bad_cmd     = nak_q || !op_valid(opcode_q);
  assign byte_valid  = !hist_mode_q || (32'(byte_idx) < SNAP_BYTES);
  assign byte_data   = hist_mode_q ? snap_q[SIDX_W'(byte_idx)] : reply_q;
  assign ledIndicators = (state_q == ST_SEND ? LED_SENDING : 8'h00)
                       | (state_q == ST_ARGS ? LED_ARGS : 8'h00)
                       | {2'b00, opcode_q[5:0]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    tx_go     = 1'b0;
    tx_len    = '0;
    tx_csum   = 1'b0;
    resethist = 1'b0;
    updatepll = 1'b0;
    case (state_q)
      ST_IDLE: if (sif.rx_ready) state_d = (nargs(sif.rx_data, NUM_PLL) != 0) ? ST_ARGS : ST_EXEC;
      ST_ARGS: if ((sif.rx_ready && arg_last) || (!sif.rx_ready && arg_timeout)) state_d = ST_EXEC;
      ST_EXEC: begin
        if (bad_cmd || opcode_q == OP_VERSION) begin
          tx_go   = 1'b1;
          tx_len  = CNT_W'(1);
          state_d = ST_SEND;
        end else if (opcode_q == OP_SEND_HIST) begin
          tx_go     = 1'b1;
          tx_len    = CNT_W'(SNAP_BYTES);
          tx_csum   = 1'b1;
          resethist = 1'b1;
          state_d   = ST_SEND;
        end else if (opcode_q == OP_SET_PLL || opcode_q == OP_RESET_PLL) begin
          state_d = ST_UPD_PLL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: if (!seq_active) state_d = ST_IDLE;
      ST_UPD_PLL: begin
        updatepll = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q             <= '0;
      argcnt_q             <= '0;
      idle_q               <= '0;
      nak_q                <= 1'b0;
      hist_mode_q          <= 1'b0;
      reply_q              <= '0;
      pll_shifts           <= '0;
      disable_line_drivers <= 1'b1;
      enable_debug_outputs <= 1'b0;
      passthrough          <= 1'b0;
      vetopmtlast          <= 3'b001;
      useInternalTestPulse <= 1'b0;
      useExternalTestPulse <= 1'b0;
      cmd_error            <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (sif.rx_ready) begin
          opcode_q <= sif.rx_data;
          argcnt_q <= '0;
          idle_q   <= '0;
          nak_q    <= 1'b0;
        end
        ST_ARGS: begin
          if (sif.rx_ready) begin
            argcnt_q <= argcnt_q + ARG_W'(1);
            idle_q   <= '0;
          end else if (arg_timeout) begin
            nak_q <= 1'b1;
          end else begin
            idle_q <= idle_q + TO_W'(1);
          end
        end
        // A timed-out command leaves every register untouched and only NAKs
        ST_EXEC: begin
          hist_mode_q <= 1'b0;
          if (bad_cmd) begin
            reply_q   <= NAK_BYTE;
            cmd_error <= 1'b1;
          end else begin
            case (opcode_q)
              OP_VERSION: begin
                reply_q   <= VERSION;
                cmd_error <= 1'b0;
              end
              OP_SET_OUTPUTS: begin
                disable_line_drivers <= !args_q[0][0];
                enable_debug_outputs <= args_q[0][1];
              end
              OP_SET_PLL: for (int k = 0; k < NUM_PLL; k++) pll_shifts[k*8 +: 8] <= args_q[k];
              OP_SET_PASSTHROUGH: passthrough <= (args_q[0] != 8'd0);
              OP_SEND_HIST:       hist_mode_q <= 1'b1;
              OP_SET_PMT_VETO:    vetopmtlast <= args_q[0][2:0];
              OP_RESET_PLL:       pll_shifts  <= '0;
              OP_SET_TEST_INPUTS: begin
                useInternalTestPulse <= args_q[0][0];
                useExternalTestPulse <= args_q[0][1];
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_ARGS && sif.rx_ready) args_q[argcnt_q] <= sif.rx_data;
    // Snapshot on the same edge the bins are cleared, so no count is double-reported
    if (resethist) for (int b = 0; b < SNAP_BYTES; b++) snap_q[b] <= snap_flat[b*8 +: 8];
  end

  serial_tx_seq #(.CNT_W(CNT_W)) u_tx_seq (
    .clk        (clk),
    .reset      (reset),
    .start      (tx_go),
    .nbytes     (tx_len),
    .with_csum  (tx_csum),
    .byte_idx   (byte_idx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .tx_busy    (sif.tx_busy),
    .tx_start   (sif.tx_start),
    .tx_data    (sif.tx_data),
    .active     (seq_active)
  );

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Directed bench for serial_cmd_engine with a simple UART transmitter model.
`timescale 1ns/1ps
module tb_serial_cmd_engine;

  localparam int NUM_HIST = 32;
  localparam int HIST_W   = 32;
  localparam int NUM_PLL  = 6;
  localparam int ARG_TO   = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_cmd_engine_if sif();

  logic [NUM_HIST*HIST_W-1:0] hist;
  logic [2*HIST_W-1:0]        hist_aux;
  logic                       resethist, updatepll;
  logic [NUM_PLL*8-1:0]       pll_shifts;
  logic                       dld, edo, pass, int_tp, ext_tp, cmd_error;
  logic [2:0]                 veto;
  logic [7:0]                 led;
  wire  [7:0]                 cfg = {dld, edo, pass, veto, int_tp, ext_tp};

  serial_cmd_engine #(
    .NUM_HIST(NUM_HIST), .HIST_W(HIST_W), .NUM_PLL(NUM_PLL),
    .VERSION(8'd24), .ARG_TIMEOUT(ARG_TO), .NAK_BYTE(8'hEE)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .sif                  (sif),
    .hist                 (hist),
    .hist_aux             (hist_aux),
    .resethist            (resethist),
    .updatepll            (updatepll),
    .pll_shifts           (pll_shifts),
    .disable_line_drivers (dld),
    .enable_debug_outputs (edo),
    .passthrough          (pass),
    .vetopmtlast          (veto),
    .useInternalTestPulse (int_tp),
    .useExternalTestPulse (ext_tp),
    .cmd_error            (cmd_error),
    .ledIndicators        (led)
  );

  // UART transmitter model: each tx_start holds busy for a few cycles
  int         uart_cnt = 0;
  logic       busy_force = 1'b0;
  logic [7:0] rxq[$];
  int         n_start = 0, n_reshist = 0, n_updpll = 0;
  assign sif.tx_busy = busy_force | (uart_cnt != 0);

  always @(negedge clk) begin
    if (sif.tx_start === 1'b1) begin
      rxq.push_back(sif.tx_data);
      n_start  <= n_start + 1;
      uart_cnt <= 4;
    end else if (uart_cnt != 0) begin
      uart_cnt <= uart_cnt - 1;
    end
    if (resethist === 1'b1) n_reshist <= n_reshist + 1;
    if (updatepll === 1'b1) n_updpll <= n_updpll + 1;
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] qbyte(input int i);
    if (i < rxq.size()) return rxq[i];
    return 8'hxx;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    sif.rx_ready = 1'b1;
    sif.rx_data  = b;
    @(negedge clk);
    sif.rx_ready = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int i;
    i = 0;
    while (rxq.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
  endtask

  typedef struct {
    logic [7:0] op;
    logic [7:0] arg;
    logic [7:0] exp_cfg;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0, s1, s2, u0, r0, errs;
    logic [7:0] expb;

    // cfg = {dld, edo, pass, veto[2:0], int, ext}, cumulative from reset value 8'h84
    vecs[0] = '{8'h01, 8'h03, 8'h44};
    vecs[1] = '{8'h03, 8'h05, 8'h64};
    vecs[2] = '{8'h05, 8'h06, 8'h78};
    vecs[3] = '{8'h07, 8'h02, 8'h79};
    vecs[4] = '{8'h07, 8'h01, 8'h7A};
    vecs[5] = '{8'h01, 8'h00, 8'hBA};
    vecs[6] = '{8'h03, 8'h00, 8'h9A};
    vecs[7] = '{8'h05, 8'h0F, 8'h9E};

    sif.rx_ready = 1'b0;
    sif.rx_data  = 8'h00;
    for (int i = 0; i < NUM_HIST; i++) hist[i*HIST_W +: HIST_W] = 32'h0100_0000 * i + i;
    hist_aux = {32'hDEADBEEF, 32'h12345678};
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_cfg", cfg, 8'h84);
    check("rst_led", led, 8'h00);
    check("rst_cmd_error", cmd_error, 1'b0);
    check("rst_tx_data", sif.tx_data, 8'h00);
    check("rst_pll", pll_shifts, 48'h0);

    // VERSION
    rxq.delete();
    send_byte(8'h00);
    wait_bytes(1, 100);
    repeat (20) @(negedge clk);
    check("ver_count", rxq.size(), 1);
    check("ver_byte", qbyte(0), 8'd24);
    check("ver_starts", n_start, 1);
    check("ver_cmd_error", cmd_error, 1'b0);

    // argument timeout
    rxq.delete();
    send_byte(8'h05);
    repeat (ARG_TO / 2) @(negedge clk);
    check("to_pending_bytes", rxq.size(), 0);
    check("to_pending_led", led, 8'h45);
    wait_bytes(1, ARG_TO);
    repeat (20) @(negedge clk);
    check("to_count", rxq.size(), 1);
    check("to_nak", qbyte(0), 8'hEE);
    check("to_cmd_error", cmd_error, 1'b1);
    check("to_veto", veto, 3'b001);

    // bad opcode
    rxq.delete();
    send_byte(8'h1F);
    wait_bytes(1, 100);
    repeat (20) @(negedge clk);
    check("bad_count", rxq.size(), 1);
    check("bad_nak", qbyte(0), 8'hEE);
    check("bad_led", led, 8'h1F);

    // single-argument configuration commands
    rxq.delete();
    for (int i = 0; i < 8; i++) begin
      send_byte(vecs[i].op);
      send_byte(vecs[i].arg);
      repeat (6) @(negedge clk);
      check($sformatf("tbl%0d_cfg", i), cfg, vecs[i].exp_cfg);
      check($sformatf("tbl%0d_led", i), led, vecs[i].op);
    end
    check("tbl_quiet", rxq.size(), 0);
    check("err_sticky", cmd_error, 1'b1);
    send_byte(8'h00);
    wait_bytes(1, 100);
    repeat (20) @(negedge clk);
    check("err_cleared", cmd_error, 1'b0);

    // PLL set / reset
    rxq.delete();
    u0 = n_updpll;
    send_byte(8'h02);
    for (int k = 1; k <= 6; k++) send_byte(8'(k));
    repeat (10) @(negedge clk);
    check("pll_val", pll_shifts, 48'h060504030201);
    check("pll_upd", n_updpll - u0, 1);
    send_byte(8'h06);
    repeat (10) @(negedge clk);
    check("pllrst_val", pll_shifts, 48'h0);
    check("pllrst_upd", n_updpll - u0, 2);
    send_byte(8'h02);
    for (int k = 1; k <= 6; k++) send_byte(8'hA0 + 8'(k));
    repeat (10) @(negedge clk);
    check("pll_val2", pll_shifts, 48'hA6A5A4A3A2A1);
    check("pll_quiet", rxq.size(), 0);

    // histogram stream; inputs change after the snapshot and must not leak in
    rxq.delete();
    r0 = n_reshist;
    send_byte(8'h04);
    wait_bytes(1, 100);
    for (int i = 0; i < NUM_HIST; i++) hist[i*HIST_W +: HIST_W] = 32'hFFFF_0000 ^ i;
    hist_aux = '0;
    wait_bytes(137, 4000);
    repeat (30) @(negedge clk);
    check("hist_len", rxq.size(), 137);
    errs = 0;
    for (int b = 0; b < 128; b++) begin
      expb = (b % 4 == 0 || b % 4 == 3) ? 8'(b / 4) : 8'h00;
      if (qbyte(b) !== expb) errs++;
    end
    check("hist_bins", errs, 0);
    check("hist_aux0", {qbyte(131), qbyte(130), qbyte(129), qbyte(128)}, 32'h12345678);
    check("hist_aux1", {qbyte(135), qbyte(134), qbyte(133), qbyte(132)}, 32'hDEADBEEF);
    check("hist_csum", qbyte(136), 8'h2A);
    check("hist_resethist", n_reshist - r0, 1);

    // bad opcode so cmd_error is set going into the reset check
    rxq.delete();
    send_byte(8'h33);
    wait_bytes(1, 100);
    repeat (20) @(negedge clk);
    check("bad2_cmd_error", cmd_error, 1'b1);

    // stall mid-stream, then reset mid-stream
    rxq.delete();
    send_byte(8'h04);
    wait_bytes(10, 500);
    busy_force = 1'b1;
    repeat (3) @(negedge clk);
    s1 = n_start;
    repeat (47) @(negedge clk);
    check("busy_no_start", n_start - s1, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_cfg", cfg, 8'h84);
    check("mid_rst_led", led, 8'h00);
    check("mid_rst_cmd_error", cmd_error, 1'b0);
    check("mid_rst_tx_start", sif.tx_start, 1'b0);
    check("mid_rst_tx_data", sif.tx_data, 8'h00);
    check("mid_rst_pll", pll_shifts, 48'h0);
    check("mid_rst_pulses", {resethist, updatepll}, 2'b00);
    reset = 1'b0;
    busy_force = 1'b0;
    s2 = n_start;
    repeat (100) @(negedge clk);
    check("abort_no_start", n_start - s2, 0);
    s0 = n_start;

    // engine still usable after the abort
    rxq.delete();
    send_byte(8'h00);
    wait_bytes(1, 100);
    repeat (20) @(negedge clk);
    check("post_rst_ver", qbyte(0), 8'd24);
    check("post_rst_starts", n_start - s0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
